// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU, cache and main-memory signals of the cache controller.
interface cache_ctrl_if #(parameter int ADDR_BITS = 32, parameter int TAG_BITS = 23);
  logic                 en_r, en_w;
  logic [ADDR_BITS-1:0] addr_rw;
  logic [2:0]           u_b_h_w;
  logic [31:0]          data_w, data_r;
  logic                 stall;
  logic [ADDR_BITS-1:0] cache_addr;
  logic                 cache_load, cache_store, cache_edit, cache_invalid;
  logic [2:0]           cache_u_b_h_w;
  logic [31:0]          cache_din, cache_dout;
  logic                 cache_hit, cache_valid, cache_dirty;
  logic [TAG_BITS-1:0]  cache_tag;
  logic                 mem_cs, mem_we, mem_ack;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_dout, mem_din;
  logic [31:0]          hit_cnt, miss_cnt;
  modport master (
    input  en_r, en_w, addr_rw, u_b_h_w, data_w,
    input  cache_hit, cache_dout, cache_valid, cache_dirty, cache_tag,
    input  mem_din, mem_ack,
    output data_r, stall,
    output cache_addr, cache_load, cache_store, cache_edit, cache_invalid, cache_u_b_h_w, cache_din,
    output mem_cs, mem_we, mem_addr, mem_dout,
    output hit_cnt, miss_cnt
  );
  modport slave (
    output en_r, en_w, addr_rw, u_b_h_w, data_w,
    output cache_hit, cache_dout, cache_valid, cache_dirty, cache_tag,
    output mem_din, mem_ack,
    input  data_r, stall,
    input  cache_addr, cache_load, cache_store, cache_edit, cache_invalid, cache_u_b_h_w, cache_din,
    input  mem_cs, mem_we, mem_addr, mem_dout,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: 2-way cache sequencer with dirty write-back, refill and replay.
// Define CACHE_CTRL_STAT_EN to build the hit/miss counters.
module cache_ctrl #(
  parameter int ADDR_BITS  = 32,
  parameter int TAG_BITS   = 23,
  parameter int INDEX_BITS = 5,
  parameter int LINE_WORDS = 4
) (
  input logic clk,
  input logic rst,
  cache_ctrl_if.master bus
);
  localparam int LB = ADDR_BITS - TAG_BITS - INDEX_BITS;
  typedef enum logic [2:0] {S_IDLE, S_TAG, S_BACK_RD, S_BACK_WR, S_FILL} state_t;
  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [TAG_BITS-1:0]   vtag_q, vtag_d;
  logic [INDEX_BITS-1:0] vidx_q, vidx_d;
  logic [31:0]           data_r_q, data_r_d, wb_q;
  logic                  ld_q, req, rd, last;
  logic [ADDR_BITS-1:0]  vaddr, faddr;
  assign req   = bus.en_r | bus.en_w;
  assign rd    = bus.en_r & ~bus.en_w;
  assign last  = cnt_q == 2'(LINE_WORDS - 1);
  assign vaddr = {vtag_q, vidx_q, cnt_q, 2'b00};
  assign faddr = {bus.addr_rw[ADDR_BITS-1:LB], cnt_q, 2'b00};
  assign bus.stall = req & ~(state_q == S_TAG & bus.cache_hit);
  assign bus.data_r = data_r_q;
  assign bus.cache_invalid = 1'b0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vtag_d = vtag_q;
    vidx_d = vidx_q;
    data_r_d = data_r_q;
    bus.cache_addr = bus.addr_rw;
    bus.cache_load = 1'b0;
    bus.cache_store = 1'b0;
    bus.cache_edit = 1'b0;
    bus.cache_din = bus.data_w;
    bus.cache_u_b_h_w = bus.u_b_h_w;
    bus.mem_cs = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = faddr;
    bus.mem_dout = ld_q ? bus.cache_dout : wb_q;
    case (state_q)
      S_IDLE: if (req) begin
        bus.cache_load = rd;
        bus.cache_edit = bus.en_w;
        state_d = S_TAG;
      end
      S_TAG: begin
        cnt_d = 2'd0;
        if (bus.cache_hit) begin
          data_r_d = rd ? bus.cache_dout : data_r_q;
          state_d = S_IDLE;
        end else if (bus.cache_valid & bus.cache_dirty) begin
          vtag_d = bus.cache_tag;
          vidx_d = bus.addr_rw[LB +: INDEX_BITS];
          state_d = S_BACK_RD;
        end else state_d = S_FILL;
      end
      S_BACK_RD: begin
        bus.cache_addr = vaddr;
        state_d = S_BACK_WR;
      end
      S_BACK_WR: begin
        bus.cache_addr = vaddr;
        bus.mem_cs = 1'b1;
        bus.mem_we = 1'b1;
        bus.mem_addr = vaddr;
        cnt_d = bus.mem_ack ? cnt_q + 2'd1 : cnt_q;
        state_d = bus.mem_ack ? (last ? S_FILL : S_BACK_RD) : S_BACK_WR;
      end
      S_FILL: begin
        bus.cache_addr = faddr;
        bus.mem_cs = 1'b1;
        bus.cache_store = bus.mem_ack;
        bus.cache_din = bus.mem_ack ? bus.mem_din : bus.data_w;
        cnt_d = bus.mem_ack ? cnt_q + 2'd1 : cnt_q;
        state_d = bus.mem_ack & last ? S_IDLE : S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // The victim word is only valid the cycle after S_BACK_RD; hold it for slow acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= 2'd0;
      vtag_q <= '0;
      vidx_q <= '0;
      data_r_q <= 32'd0;
      wb_q <= 32'd0;
      ld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vtag_q <= vtag_d;
      vidx_q <= vidx_d;
      data_r_q <= data_r_d;
      wb_q <= ld_q ? bus.cache_dout : wb_q;
      ld_q <= state_q == S_BACK_RD;
    end
  end
`ifdef CACHE_CTRL_STAT_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d;
  logic        rp_q, rp_d, tag_c;
  assign tag_c  = state_q == S_TAG;
  assign hit_d  = hit_q + {31'd0, tag_c & bus.cache_hit & ~rp_q};
  assign miss_d = miss_q + {31'd0, tag_c & ~bus.cache_hit};
  assign rp_d   = (state_q == S_FILL & state_d == S_IDLE) | (rp_q & ~tag_c);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q <= 32'd0;
      miss_q <= 32'd0;
      rp_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
      miss_q <= miss_d;
      rp_q <= rp_d;
    end
  end
  assign bus.hit_cnt  = hit_q;
  assign bus.miss_cnt = miss_q;
`else
  assign bus.hit_cnt  = 32'd0;
  assign bus.miss_cnt = 32'd0;
`endif
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Cache management unit between the CPU data-memory port and the 2-way set-associative data cache (32 sets, 4-word lines, 23/5/2/2 tag/index/word/byte split).
- Sequences the cache's load/store/edit/invalid strobes and stalls the CPU on a miss.
- On a miss, writes back a dirty victim line to main memory word-by-word, refills the line, then replays the access.
- Main memory is a single-word req/ack slave.

Parameters:
- ADDR_BITS, 32, address width
- TAG_BITS, 23, tag width; must match cache
- INDEX_BITS, 5, set-index width
- LINE_WORDS, 4, words per line; fixed, counter is 2 bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en_r  in  1  CPU read request
- en_w  in  1  CPU write request
- addr_rw  in  32  CPU byte address
- u_b_h_w  in  3  width/sign select, passed to cache
- data_w  in  32  CPU write data
- data_r  out  32  CPU read data
- stall  out  1  CPU must hold request
- cache_addr  out  32  cache address
- cache_load  out  1  cache load strobe
- cache_store  out  1  cache store strobe
- cache_edit  out  1  cache edit strobe
- cache_invalid  out  1  cache invalidate strobe
- cache_u_b_h_w  out  3  cache width select
- cache_din  out  32  cache write data
- cache_hit  in  1  cache hit, registered
- cache_dout  in  32  cache read data, registered
- cache_valid  in  1  victim valid, registered
- cache_dirty  in  1  victim dirty, registered
- cache_tag  in  23  victim tag, registered
- mem_cs  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory word address, low 2 bits 0
- mem_dout  out  32  memory write data
- mem_din  in  32  memory read data
- mem_ack  in  1  memory transfer done, 1 cycle
- hit_cnt  out  32  hit counter
- miss_cnt  out  32  miss counter

Behaviour:
- Reset (rst=0, asynchronous): state to S_IDLE, word counter 0; all strobes and mem_cs/mem_we 0; data_r 0. Cache contents untouched. If reset lands mid-transfer, mem_cs drops immediately and the partial line stays as written.
- Request rule: req = en_r | en_w. If both are high, write wins and the load is suppressed. The CPU holds addr/data/en stable while stall=1.
- stall = req & ~(state==S_TAG & cache_hit). This is combinational.
- S_IDLE:
  - If req: cache_addr=addr_rw, cache_load=en_r&~en_w, cache_edit=en_w, cache_din=data_w, cache_u_b_h_w=u_b_h_w, then go to S_TAG.
  - Otherwise all strobes stay 0.
- S_TAG (cache outputs now reflect the lookup):
  - On hit: data_r<=cache_dout (read), stall low this cycle, go to S_IDLE. Hit latency is 2 cycles, request to release.
  - On miss with cache_valid & cache_dirty: latch victim tag and set index, counter=0, go to S_BACK_RD.
  - On any other miss: go to S_FILL.
- S_BACK_RD: cache_addr={vtag,index,cnt,2'b00}, cache_load=0 (cache presents the victim word without touching the recent bit), go to S_BACK_WR.
- S_BACK_WR:
  - mem_cs=1, mem_we=1, mem_addr={vtag,index,cnt,00}, mem_dout=cache_dout (held in a register captured on entry).
  - On mem_ack: cnt++; if cnt was 3, go to S_FILL with cnt=0, else go to S_BACK_RD.
- S_FILL:
  - mem_cs=1, mem_we=0, mem_addr={addr_rw[31:4],cnt,00}.
  - On mem_ack: cache_store=1 same cycle, cache_addr={addr_rw[31:4],cnt,00}, cache_din=mem_din; cnt++.
  - After word 3, go to S_IDLE, which replays the lookup.
  - The recent bit is unchanged during fill, so all 4 stores land in the same way.
- Replay always hits. Miss penalty = 4*(1+ack latency) for fill, plus 4*(2+ack latency) if dirty.
- cnt wraps 3->0. mem_ack outside S_BACK_WR/S_FILL is ignored.
- cache_invalid is driven 0 permanently (reserved).

Optional Feature:
- CACHE_CTRL_STAT_EN defined: hit_cnt increments on each S_TAG hit that is not a replay; miss_cnt increments on each S_TAG miss. Both are 32-bit, wrap at 2^32, and are cleared by rst.
- Undefined: hit_cnt and miss_cnt are tied to 0 and no counter flops are instantiated.

Test Plan:
- Cold read: en_r=1, addr 0x0000_0100, memory words 0x11,0x22,0x33,0x44 at 0x100..0x10C -> 4 mem reads, 4 cache_store pulses, replay hit, data_r=0x11, miss_cnt=1.
- Read hit: after the above, en_r=1, addr 0x104, u_b_h_w=010 -> stall high exactly 1 cycle, data_r=0x22, no mem_cs, hit_cnt=1.
- Dirty eviction: write 0xDEADBEEF to 0x100, then read 0x300 and 0x500 (same set 0x10) -> second miss writes back 4 words to 0x100..0x10C with word0=0xDEADBEEF before filling 0x500.
- Clean eviction: repeat without the write -> no mem_we pulses, fill only.
- Reset mid-fill: drop rst after the 2nd mem_ack -> mem_cs=0 in the same cycle, state S_IDLE, stall=0 with en low.
- Simultaneous en_r=en_w=1, addr 0x100, data_w=0x5A -> cache_edit=1, cache_load=0, subsequent read returns 0x5A.
